// File: rtl/pzvip_corebus_sram_slave.sv
// ---------------------------------------------------------------------------
// pzvip_corebus_sram_slave
//
// Corebus slave endpoint backed by a flop-based word memory. It handles one
// command at a time: it accepts a command, then either collects the write
// data beats or streams the read beats, and then produces the response.
// All outputs come straight from flops.
//
// Ports
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_mcmd_valid / o_scmd_accept   command handshake
//   i_mcmd, i_mid, i_maddr,        command (0 READ, 1 WRITE posted,
//   i_mlength                      2 WRITE_NON_POSTED, 3 reserved), id,
//                                  byte address, burst length (0 = max)
//   i_mdata_valid / o_sdata_accept write data handshake
//   i_mdata, i_mdata_byteen,       write data, byte enables, last beat
//   i_mdata_last
//   o_sresp_valid / i_mresp_accept response handshake
//   o_sresp, o_sid, o_serror,      response kind (1 = with data), echoed id,
//   o_sdata, o_sresp_last          error flag, read data, last beat
// ---------------------------------------------------------------------------
module pzvip_corebus_sram_slave #(
  parameter int ID_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int LENGTH_WIDTH = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_mcmd_valid,
  output logic                      o_scmd_accept,
  input  logic [1:0]                i_mcmd,
  input  logic [ID_WIDTH-1:0]       i_mid,
  input  logic [ADDR_WIDTH-1:0]     i_maddr,
  input  logic [LENGTH_WIDTH-1:0]   i_mlength,
  input  logic                      i_mdata_valid,
  output logic                      o_sdata_accept,
  input  logic [DATA_WIDTH-1:0]     i_mdata,
  input  logic [DATA_WIDTH/8-1:0]   i_mdata_byteen,
  input  logic                      i_mdata_last,
  output logic                      o_sresp_valid,
  input  logic                      i_mresp_accept,
  output logic                      o_sresp,
  output logic [ID_WIDTH-1:0]       o_sid,
  output logic                      o_serror,
  output logic [DATA_WIDTH-1:0]     o_sdata,
  output logic                      o_sresp_last
);

  localparam int BYTE_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BYTE_W);
  localparam int IDX_W  = $clog2(DEPTH);
  // One extra bit so that the 2**LENGTH_WIDTH burst and beat overrun fit.
  localparam int BEAT_W = LENGTH_WIDTH + 1;

  localparam logic [1:0] CMD_READ     = 2'd0;
  localparam logic [1:0] CMD_WRITE    = 2'd1;
  localparam logic [1:0] CMD_WRITE_NP = 2'd2;
  localparam logic [1:0] CMD_RSVD     = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WDATA  = 2'd1,
    RDRESP = 2'd2,
    WRESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [IDX_W-1:0]      word_q, word_d;
  logic [BEAT_W-1:0]     beats_q, beats_d;
  logic [BEAT_W-1:0]     cnt_q, cnt_d;
  logic                  range_err_q, range_err_d;
  logic                  len_err_q, len_err_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic                  scmd_accept_q, scmd_accept_d;
  logic                  sdata_accept_q, sdata_accept_d;
  logic                  sresp_valid_q, sresp_valid_d;
  logic                  sresp_q, sresp_d;
  logic [ID_WIDTH-1:0]   sid_q, sid_d;
  logic                  serror_q, serror_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic                  sresp_last_q, sresp_last_d;

  logic [ADDR_WIDTH-1:0] addr_word_s;
  logic [IDX_W-1:0]      addr_idx_s;
  logic                  addr_oor_s;
  logic [BEAT_W-1:0]     cmd_beats_s;
  logic [BEAT_W-1:0]     cnt_inc_s;
  logic                  rd_last_s;

  // Word index of the command; any index bit above the memory size is an
  // out-of-range access (the index is not folded into the array).
  assign addr_word_s = i_maddr >> OFF_W;
  assign addr_idx_s  = addr_word_s[IDX_W-1:0];
  assign addr_oor_s  = |(addr_word_s >> IDX_W);
  assign cmd_beats_s = (i_mlength == '0) ? {1'b1, {LENGTH_WIDTH{1'b0}}}
                                         : {1'b0, i_mlength};

  // The beat counter saturates so that a runaway write burst can never
  // wrap back onto the commanded count and hide a length error.
  assign cnt_inc_s = (cnt_q == {BEAT_W{1'b1}}) ? cnt_q : cnt_q + BEAT_W'(1);
  assign rd_last_s = (cnt_q == beats_q - BEAT_W'(1));

  // Next-state, burst context and memory update.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    id_d        = id_q;
    word_d      = word_q;
    beats_d     = beats_q;
    cnt_d       = cnt_q;
    range_err_d = range_err_q;
    len_err_d   = len_err_q;
    mem_d       = mem_q;
    case (state_q)
      IDLE: begin
        if (i_mcmd_valid && scmd_accept_q) begin
          cmd_d       = i_mcmd;
          id_d        = i_mid;
          word_d      = addr_idx_s;
          beats_d     = cmd_beats_s;
          cnt_d       = '0;
          range_err_d = addr_oor_s;
          len_err_d   = 1'b0;
          case (i_mcmd)
            CMD_READ:               state_d = RDRESP;
            CMD_WRITE, CMD_WRITE_NP: state_d = WDATA;
            default:                state_d = WRESP;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      WDATA: begin
        if (i_mdata_valid && sdata_accept_q) begin
          // Beats beyond the commanded count are consumed but not stored.
          if (!range_err_q && (cnt_q < beats_q)) begin
            for (int b = 0; b < BYTE_W; b++) begin
              mem_d[word_q][8*b +: 8] = i_mdata_byteen[b] ? i_mdata[8*b +: 8]
                                                          : mem_q[word_q][8*b +: 8];
            end
          end else begin
            mem_d = mem_q;
          end
          word_d = word_q + IDX_W'(1);
          cnt_d  = cnt_inc_s;
          if (i_mdata_last) begin
            len_err_d = (cnt_inc_s != beats_q);
            state_d   = (cmd_q == CMD_WRITE) ? IDLE : WRESP;
          end else begin
            state_d = WDATA;
          end
        end else begin
          state_d = WDATA;
        end
      end
      RDRESP: begin
        if (i_mresp_accept && sresp_valid_q) begin
          if (rd_last_s) begin
            state_d = IDLE;
          end else begin
            cnt_d  = cnt_inc_s;
            word_d = word_q + IDX_W'(1);
          end
        end else begin
          state_d = RDRESP;
        end
      end
      WRESP: begin
        if (i_mresp_accept && sresp_valid_q) begin
          state_d = IDLE;
        end else begin
          state_d = WRESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so that
  // every output is a flop and stays frozen while a response is stalled.
  always_comb begin
    scmd_accept_d  = 1'b0;
    sdata_accept_d = 1'b0;
    sresp_valid_d  = 1'b0;
    sresp_d        = 1'b0;
    sid_d          = '0;
    serror_d       = 1'b0;
    sdata_d        = '0;
    sresp_last_d   = 1'b0;
    case (state_d)
      IDLE: begin
        scmd_accept_d = 1'b1;
      end
      WDATA: begin
        sdata_accept_d = 1'b1;
      end
      RDRESP: begin
        sresp_valid_d = 1'b1;
        sresp_d       = 1'b1;
        sid_d         = id_d;
        serror_d      = range_err_d;
        sdata_d       = range_err_d ? '0 : mem_q[word_d];
        sresp_last_d  = (cnt_d == beats_d - BEAT_W'(1));
      end
      WRESP: begin
        sresp_valid_d = 1'b1;
        sid_d         = id_d;
        serror_d      = range_err_d | len_err_d | (cmd_d == CMD_RSVD);
        sresp_last_d  = 1'b1;
      end
      default: begin
        scmd_accept_d = 1'b0;
      end
    endcase
  end

  // State, burst context, memory and output registers; reset clears all.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      cmd_q          <= 2'd0;
      id_q           <= '0;
      word_q         <= '0;
      beats_q        <= '0;
      cnt_q          <= '0;
      range_err_q    <= 1'b0;
      len_err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      scmd_accept_q  <= 1'b0;
      sdata_accept_q <= 1'b0;
      sresp_valid_q  <= 1'b0;
      sresp_q        <= 1'b0;
      sid_q          <= '0;
      serror_q       <= 1'b0;
      sdata_q        <= '0;
      sresp_last_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      id_q           <= id_d;
      word_q         <= word_d;
      beats_q        <= beats_d;
      cnt_q          <= cnt_d;
      range_err_q    <= range_err_d;
      len_err_q      <= len_err_d;
      mem_q          <= mem_d;
      scmd_accept_q  <= scmd_accept_d;
      sdata_accept_q <= sdata_accept_d;
      sresp_valid_q  <= sresp_valid_d;
      sresp_q        <= sresp_d;
      sid_q          <= sid_d;
      serror_q       <= serror_d;
      sdata_q        <= sdata_d;
      sresp_last_q   <= sresp_last_d;
    end
  end

  assign o_scmd_accept  = scmd_accept_q;
  assign o_sdata_accept = sdata_accept_q;
  assign o_sresp_valid  = sresp_valid_q;
  assign o_sresp        = sresp_q;
  assign o_sid          = sid_q;
  assign o_serror       = serror_q;
  assign o_sdata        = sdata_q;
  assign o_sresp_last   = sresp_last_q;

endmodule

// File: tb/tb_pzvip_corebus_sram_slave.sv
// ---------------------------------------------------------------------------
// Self-checking bench for pzvip_corebus_sram_slave (default parameters:
// 32-bit data, 64 words, 4-bit length). Directed table, hand-written corner
// sequences and randomized traffic, all checked against a word-array model.
// ---------------------------------------------------------------------------
module tb_pzvip_corebus_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_mcmd_valid;
  logic        o_scmd_accept;
  logic [1:0]  i_mcmd;
  logic [3:0]  i_mid;
  logic [31:0] i_maddr;
  logic [3:0]  i_mlength;
  logic        i_mdata_valid;
  logic        o_sdata_accept;
  logic [31:0] i_mdata;
  logic [3:0]  i_mdata_byteen;
  logic        i_mdata_last;
  logic        o_sresp_valid;
  logic        i_mresp_accept;
  logic        o_sresp;
  logic [3:0]  o_sid;
  logic        o_serror;
  logic [31:0] o_sdata;
  logic        o_sresp_last;

  always #5 clk = ~clk;

  pzvip_corebus_sram_slave dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_mcmd_valid   (i_mcmd_valid),
    .o_scmd_accept  (o_scmd_accept),
    .i_mcmd         (i_mcmd),
    .i_mid          (i_mid),
    .i_maddr        (i_maddr),
    .i_mlength      (i_mlength),
    .i_mdata_valid  (i_mdata_valid),
    .o_sdata_accept (o_sdata_accept),
    .i_mdata        (i_mdata),
    .i_mdata_byteen (i_mdata_byteen),
    .i_mdata_last   (i_mdata_last),
    .o_sresp_valid  (o_sresp_valid),
    .i_mresp_accept (i_mresp_accept),
    .o_sresp        (o_sresp),
    .o_sid          (o_sid),
    .o_serror       (o_serror),
    .o_sdata        (o_sdata),
    .o_sresp_last   (o_sresp_last)
  );

  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  int          acc_mode = 0;     // 0: accept held high, 1: random, 2: toggling
  logic        tog      = 1'b0;
  logic [31:0] mdl [64];         // reference memory image

  typedef struct {
    logic [1:0]  cmd;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    int          nbeats;         // data beats sent (write) / beats expected (read)
    logic [31:0] d0, d1;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] e0, e1, e2;
  } vec_t;

  vec_t tab [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference write: stores the enabled bytes of the first 'beats' beats at
  // consecutive words (mod 64) unless the start word is past the array.
  function automatic logic model_write(input logic [31:0] a, input logic [3:0] l, input int nsent,
                                       input logic [31:0] d [20], input logic [3:0] be [20]);
    logic [31:0] w     = a >> 2;
    logic        oor   = (w >= 32'd64);
    int          beats = (l == 4'd0) ? 16 : int'(l);
    for (int i = 0; i < nsent; i++) begin
      if (!oor && i < beats) begin
        for (int b = 0; b < 4; b++) begin
          if (be[i][b]) mdl[int'((w + 32'(i)) % 32'd64)][8*b +: 8] = d[i][8*b +: 8];
        end
      end
    end
    return oor || (nsent != beats);
  endfunction

  function automatic void model_read(input logic [31:0] a, input logic [3:0] l,
                                     output logic [31:0] e [16], output logic err, output int nb);
    logic [31:0] w = a >> 2;
    err = (w >= 32'd64);
    nb  = (l == 4'd0) ? 16 : int'(l);
    for (int k = 0; k < 16; k++) begin
      e[k] = (err || k >= nb) ? 32'h0 : mdl[int'((w + 32'(k)) % 32'd64)];
    end
  endfunction

  task automatic do_cmd(input logic [1:0] c, input logic [3:0] id, input logic [31:0] a,
                        input logic [3:0] l);
    int n = 0;
    i_mcmd_valid = 1'b1; i_mcmd = c; i_mid = id; i_maddr = a; i_mlength = l;
    while (!o_scmd_accept && n < 20) begin tick(); n++; end
    if (!o_scmd_accept) chk("cmd_accept_timeout", 64'(o_scmd_accept), 64'd1);
    tick();
    i_mcmd_valid = 1'b0;
  endtask

  task automatic send_data(input logic [31:0] d, input logic [3:0] be, input logic last,
                           input bit gap);
    int n = 0;
    if (gap) tick();
    i_mdata_valid = 1'b1; i_mdata = d; i_mdata_byteen = be; i_mdata_last = last;
    while (!o_sdata_accept && n < 20) begin tick(); n++; end
    if (!o_sdata_accept) chk("data_accept_timeout", 64'(o_sdata_accept), 64'd1);
    tick();
    i_mdata_valid = 1'b0; i_mdata_last = 1'b0;
  endtask

  // Waits for one response beat, comparing every field on every cycle the
  // beat is presented (so a stalled beat must stay stable).
  task automatic get_resp(input string name, input logic sresp, input logic err,
                          input logic [31:0] data, input logic last, input logic [3:0] id,
                          output int waited);
    int n = 0;
    bit done = 0;
    waited = 0;
    while (!done && n < 80) begin
      case (acc_mode)
        0:       i_mresp_accept = 1'b1;
        1:       i_mresp_accept = 1'($urandom_range(0, 1));
        default: begin tog = ~tog; i_mresp_accept = tog; end
      endcase
      if (o_sresp_valid) begin
        chk({name, "_sresp"}, 64'(o_sresp), 64'(sresp));
        chk({name, "_sid"}, 64'(o_sid), 64'(id));
        chk({name, "_serror"}, 64'(o_serror), 64'(err));
        chk({name, "_sdata"}, 64'(o_sdata), 64'(data));
        chk({name, "_last"}, 64'(o_sresp_last), 64'(last));
        done = i_mresp_accept;
      end else begin
        waited++;
      end
      tick();
      n++;
    end
    i_mresp_accept = 1'b0;
    if (!done) begin
      vec_cnt++; miss_cnt++;
      $display("FAIL %s_timeout: no response handshake, actual valid=%0b required 1", name, o_sresp_valid);
    end
  endtask

  task automatic rd_txn(input string name, input logic [3:0] id, input logic [31:0] a,
                        input logic [3:0] l, input int nb, input logic [31:0] e [16],
                        input logic err, input bit lat);
    int w;
    do_cmd(2'd0, id, a, l);
    for (int k = 0; k < nb; k++) begin
      get_resp($sformatf("%s_b%0d", name, k), 1'b1, err, e[k], (k == nb - 1), id, w);
      if (lat) chk($sformatf("%s_b%0d_latency", name, k), 64'(w), 64'd0);
    end
    chk({name, "_done"}, 64'(o_sresp_valid), 64'd0);
  endtask

  task automatic wr_txn(input string name, input bit np, input logic [3:0] id, input logic [31:0] a,
                        input logic [3:0] l, input int nsent, input logic [31:0] d [20],
                        input logic [3:0] be [20], input logic err, input bit gaps);
    int w;
    do_cmd(np ? 2'd2 : 2'd1, id, a, l);
    for (int i = 0; i < nsent; i++) begin
      send_data(d[i], be[i], (i == nsent - 1), gaps ? bit'($urandom_range(0, 1)) : 1'b0);
    end
    if (np) begin
      get_resp({name, "_wresp"}, 1'b0, err, 32'h0, 1'b1, id, w);
      if (acc_mode == 0) chk({name, "_wresp_latency"}, 64'(w), 64'd0);
    end else begin
      chk({name, "_posted_noresp"}, 64'(o_sresp_valid), 64'd0);
      tick();
      chk({name, "_posted_noresp2"}, 64'(o_sresp_valid), 64'd0);
    end
    chk({name, "_done"}, 64'(o_sresp_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d [20];
    logic [3:0]  be [20];
    logic [31:0] e [16];
    logic        err;
    int          nb;
    int          w;
    logic [31:0] a;
    logic [3:0]  l, id;
    int          beats, nsent, r, v;

    //            cmd   id     addr      len  nb d0            d1            be     err   e0            e1            e2
    tab[0]  = '{2'd2, 4'h3, 32'h10,  4'd2, 2, 32'hAAAA5555, 32'h12345678, 4'hF, 1'b0, 32'h0,        32'h0,        32'h0};
    tab[1]  = '{2'd0, 4'h5, 32'h10,  4'd2, 2, 32'h0,        32'h0,        4'h0, 1'b0, 32'hAAAA5555, 32'h12345678, 32'h0};
    tab[2]  = '{2'd1, 4'h6, 32'h0,   4'd1, 1, 32'hFFFFFFFF, 32'h0,        4'h5, 1'b0, 32'h0,        32'h0,        32'h0};
    tab[3]  = '{2'd0, 4'h7, 32'h0,   4'd1, 1, 32'h0,        32'h0,        4'h0, 1'b0, 32'h00FF00FF, 32'h0,        32'h0};
    tab[4]  = '{2'd0, 4'h8, 32'h100, 4'd3, 3, 32'h0,        32'h0,        4'h0, 1'b1, 32'h0,        32'h0,        32'h0};
    tab[5]  = '{2'd2, 4'h9, 32'h100, 4'd1, 1, 32'hDEADBEEF, 32'h0,        4'hF, 1'b1, 32'h0,        32'h0,        32'h0};
    tab[6]  = '{2'd0, 4'hA, 32'h0,   4'd1, 1, 32'h0,        32'h0,        4'h0, 1'b0, 32'h00FF00FF, 32'h0,        32'h0};
    tab[7]  = '{2'd2, 4'hB, 32'h20,  4'd3, 2, 32'h11111111, 32'h22222222, 4'hF, 1'b1, 32'h0,        32'h0,        32'h0};
    tab[8]  = '{2'd0, 4'hC, 32'h20,  4'd3, 3, 32'h0,        32'h0,        4'h0, 1'b0, 32'h11111111, 32'h22222222, 32'h0};
    tab[9]  = '{2'd2, 4'hD, 32'h40,  4'd1, 2, 32'h33333333, 32'h44444444, 4'hF, 1'b1, 32'h0,        32'h0,        32'h0};
    tab[10] = '{2'd0, 4'hE, 32'h40,  4'd2, 2, 32'h0,        32'h0,        4'h0, 1'b0, 32'h33333333, 32'h0,        32'h0};
    tab[11] = '{2'd2, 4'h1, 32'h13,  4'd1, 1, 32'hCAFEF00D, 32'h0,        4'hA, 1'b0, 32'h0,        32'h0,        32'h0};
    tab[12] = '{2'd0, 4'h2, 32'h12,  4'd1, 1, 32'h0,        32'h0,        4'h0, 1'b0, 32'hCAAAF055, 32'h0,        32'h0};

    for (int i = 0; i < 64; i++) mdl[i] = 32'h0;
    rst_n = 1'b0; i_mcmd_valid = 1'b0; i_mcmd = 2'd0; i_mid = 4'd0; i_maddr = 32'd0;
    i_mlength = 4'd0; i_mdata_valid = 1'b0; i_mdata = 32'd0; i_mdata_byteen = 4'd0;
    i_mdata_last = 1'b0; i_mresp_accept = 1'b0;

    // Reset values.
    #3;
    chk("rst_scmd_accept", 64'(o_scmd_accept), 64'd0);
    chk("rst_sdata_accept", 64'(o_sdata_accept), 64'd0);
    chk("rst_outputs", 64'({o_sresp_valid, o_sresp, o_sid, o_serror, o_sdata, o_sresp_last}), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_scmd_accept", 64'(o_scmd_accept), 64'd1);

    // Directed table.
    acc_mode = 0;
    for (int t = 0; t < 13; t++) begin
      for (int k = 0; k < 20; k++) begin d[k] = 32'h0; be[k] = tab[t].be; end
      d[0] = tab[t].d0; d[1] = tab[t].d1;
      for (int k = 0; k < 16; k++) e[k] = 32'h0;
      e[0] = tab[t].e0; e[1] = tab[t].e1; e[2] = tab[t].e2;
      if (tab[t].cmd == 2'd0) begin
        rd_txn($sformatf("tab%0d", t), tab[t].id, tab[t].addr, tab[t].len, tab[t].nbeats, e,
               tab[t].exp_err, 1'b1);
      end else begin
        void'(model_write(tab[t].addr, tab[t].len, tab[t].nbeats, d, be));
        wr_txn($sformatf("tab%0d", t), (tab[t].cmd == 2'd2), tab[t].id, tab[t].addr, tab[t].len,
               tab[t].nbeats, d, be, tab[t].exp_err, 1'b0);
      end
    end

    // Write data offered in IDLE must be ignored.
    i_mdata_valid = 1'b1; i_mdata = 32'hBADBAD00; i_mdata_byteen = 4'hF; i_mdata_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("idle_data_noaccept%0d", k), 64'(o_sdata_accept), 64'd0);
      tick();
    end
    i_mdata_valid = 1'b0; i_mdata_last = 1'b0;
    model_read(32'h0, 4'd1, e, err, nb);
    rd_txn("idle_data_ignored", 4'h4, 32'h0, 4'd1, nb, e, err, 1'b1);

    // Reserved command: one error response without data.
    do_cmd(2'd3, 4'h2, 32'h8, 4'd4);
    get_resp("reserved", 1'b0, 1'b1, 32'h0, 1'b1, 4'h2, w);
    chk("reserved_single_beat", 64'(o_sresp_valid), 64'd0);

    // 16-beat wrap: posted write then read from word 60 with accept toggling.
    for (int k = 0; k < 20; k++) begin d[k] = $urandom; be[k] = 4'hF; end
    err = model_write(32'hF0, 4'd0, 16, d, be);
    wr_txn("wrap_wr", 1'b0, 4'h6, 32'hF0, 4'd0, 16, d, be, err, 1'b0);
    acc_mode = 2;
    model_read(32'hF0, 4'd0, e, err, nb);
    rd_txn("wrap_rd", 4'h9, 32'hF0, 4'd0, nb, e, err, 1'b0);

    // Randomized traffic against the model.
    acc_mode = 1;
    for (int t = 0; t < 40; t++) begin
      r  = int'($urandom_range(0, 9));
      id = 4'($urandom_range(0, 15));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a = a + 32'h100 * 32'($urandom_range(1, 3));
      l  = 4'($urandom_range(0, 15));
      beats = (l == 4'd0) ? 16 : int'(l);
      if (r < 4) begin
        model_read(a, l, e, err, nb);
        rd_txn($sformatf("rnd%0d_rd", t), id, a, l, nb, e, err, 1'b0);
      end else if (r < 9) begin
        nsent = beats;
        v = int'($urandom_range(0, 5));
        if (v == 0) nsent = beats + 1;
        if (v == 1 && beats > 1) nsent = beats - 1;
        for (int k = 0; k < 20; k++) begin d[k] = $urandom; be[k] = 4'($urandom_range(0, 15)); end
        err = model_write(a, l, nsent, d, be);
        wr_txn($sformatf("rnd%0d_wr", t), (r >= 6), id, a, l, nsent, d, be, err, 1'b1);
      end else begin
        do_cmd(2'd3, id, a, l);
        get_resp($sformatf("rnd%0d_rsvd", t), 1'b0, 1'b1, 32'h0, 1'b1, id, w);
      end
    end

    // Reset in the middle of a read burst.
    acc_mode = 0;
    for (int k = 0; k < 20; k++) begin d[k] = 32'h5A5A5A5A; be[k] = 4'hF; end
    err = model_write(32'h14, 4'd1, 1, d, be);
    wr_txn("pre_rst_wr", 1'b1, 4'h5, 32'h14, 4'd1, 1, d, be, err, 1'b0);
    do_cmd(2'd0, 4'h7, 32'h14, 4'd4);
    chk("mid_read_valid", 64'(o_sresp_valid), 64'd1);
    chk("mid_read_data", 64'(o_sdata), 64'h5A5A5A5A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(o_sresp_valid), 64'd0);
    chk("async_rst_accept", 64'(o_scmd_accept), 64'd0);
    chk("async_rst_sdata", 64'(o_sdata), 64'd0);
    for (int i = 0; i < 64; i++) mdl[i] = 32'h0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_noresp", 64'(o_sresp_valid), 64'd0);
    chk("post_rst_accept", 64'(o_scmd_accept), 64'd1);
    model_read(32'h14, 4'd1, e, err, nb);
    rd_txn("post_rst_rd", 4'h8, 32'h14, 4'd1, nb, e, err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/pzvip_corebus_sram_slave.md
Name: pzvip_corebus_sram_slave

Overview:
- Synthesizable corebus slave endpoint backed by a flop-based word memory.
- Sits directly downstream of a corebus master: it consumes the command and write-data channels and produces the response channel.
- Serves as a reference DUT and loopback target for corebus VIP master agents, and as a simple memory in unit-level benches.
- Processes one command at a time. No reordering and no outstanding-command queue.

Parameters:
- ID_WIDTH, 4, width of i_mid / o_sid
- ADDR_WIDTH, 32, byte address width of i_maddr
- LENGTH_WIDTH, 4, width of i_mlength; burst beats = i_mlength, and 0 encodes 2**LENGTH_WIDTH beats
- DATA_WIDTH, 32, data width; must be a power of two and at least 8
- DEPTH, 64, memory depth in DATA_WIDTH words; must be a power of two

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_mcmd_valid  input  1  command valid
- o_scmd_accept  output  1  command accept
- i_mcmd  input  2  command: 0 READ, 1 WRITE (posted), 2 WRITE_NON_POSTED, 3 reserved
- i_mid  input  ID_WIDTH  command id
- i_maddr  input  ADDR_WIDTH  byte start address
- i_mlength  input  LENGTH_WIDTH  burst length
- i_mdata_valid  input  1  write data valid
- o_sdata_accept  output  1  write data accept
- i_mdata  input  DATA_WIDTH  write data
- i_mdata_byteen  input  DATA_WIDTH/8  byte enables
- i_mdata_last  input  1  last write beat
- o_sresp_valid  output  1  response valid
- i_mresp_accept  input  1  response accept
- o_sresp  output  1  0 RESPONSE (no data), 1 RESPONSE_WITH_DATA
- o_sid  output  ID_WIDTH  id echoed from the command
- o_serror  output  1  error flag
- o_sdata  output  DATA_WIDTH  read data
- o_sresp_last  output  1  last response beat

Behaviour:
- Clocking and reset
  - Single clock i_clk. Reset i_rst_n is asynchronous, active-low.
  - All state is cleared on reset, including all memory words (zeroed).
- Output reset values
  - o_scmd_accept=0 while i_rst_n=0.
  - o_sdata_accept, o_sresp_valid, o_sresp, o_sid, o_serror, o_sdata and o_sresp_last are all 0.
- Handshakes
  - A transfer occurs on any channel when valid and accept are both high at posedge i_clk.
  - Once o_sresp_valid is high, the slave holds it and all response fields stable until i_mresp_accept.
- Address mapping
  - Word index = i_maddr >> log2(DATA_WIDTH/8).
  - The low address bits are ignored.
  - The command is out-of-range when any word-index bit at or above log2(DEPTH) is set.
  - Beat addresses increment by one word and wrap modulo DEPTH.
- FSM states: IDLE, WDATA, RDRESP, WRESP.
- IDLE
  - o_scmd_accept=1 (reset released); all other outputs are 0.
  - On a command handshake, the slave captures mcmd, mid, word index, beat count (0 encodes 2**LENGTH_WIDTH) and the range-error flag.
  - Transitions: READ -> RDRESP; WRITE or WRITE_NON_POSTED -> WDATA; reserved -> WRESP with error=1.
- WDATA
  - o_scmd_accept=0, o_sdata_accept=1.
  - Each beat writes the bytes whose i_mdata_byteen bit is set to the current word.
  - The write is suppressed when the range-error flag is set, or when more than the commanded beat count has already been received.
  - The phase ends on the beat with i_mdata_last=1.
  - If that beat's index is not equal to the beat count, the length-error flag is set.
  - Exit: posted WRITE -> IDLE (errors discarded); WRITE_NON_POSTED -> WRESP.
- WRESP
  - Single beat: o_sresp_valid=1, o_sresp=0, o_sresp_last=1, o_sdata=0.
  - o_serror = range error OR length error OR reserved command.
  - On accept -> IDLE.
- RDRESP
  - o_sresp_valid=1, o_sresp=1, o_sdata=mem[current word].
  - When the range-error flag is set, o_sdata=0 and o_serror=1 on every beat.
  - The address and beat counter advance on each accept.
  - o_sresp_last=1 on the final beat; accept of the final beat -> IDLE.
- Latency
  - First read beat is valid in the cycle after the command handshake.
  - Write response is valid in the cycle after the mdata_last handshake.
  - Sustained read throughput is 1 beat per cycle with i_mresp_accept held high.
  - One idle cycle separates back-to-back commands (accept is re-asserted in IDLE).
- Data-channel ordering
  - Data presented before or after a write command is not accepted outside WDATA.
  - i_mdata_valid while in IDLE is ignored.
- Reset mid-operation
  - Any state returns to IDLE asynchronously; the in-flight burst is dropped with no response.
  - Memory is cleared.

Test Plan:
- Non-posted write, addr 0x10, len 2, data 0xAAAA5555 then 0x12345678, byteen 0xF -> one response sresp=0, serror=0, sid echoed; then READ addr 0x10 len 2 -> beats 0xAAAA5555, 0x12345678, with last on beat 2.
- Posted write addr 0x0, data 0xFFFFFFFF, byteen 0x5, after reset -> no response; READ addr 0x0 len 1 -> 0x00FF00FF.
- READ addr 0x100, DEPTH=64 (out-of-range) len 3 -> 3 beats with sdata=0 and serror=1; a write to the same address leaves memory unchanged.
- Non-posted write len 3 with mdata_last on beat 2 -> response serror=1; beats 1-2 written. Len 1 with last on beat 2 -> beat 2 dropped, serror=1.
- READ len 0 (16 beats) at word 60 with i_mresp_accept toggling 1/0 -> words 60..63 then 0..11 in order, fields stable while unaccepted, last on beat 16.
- Reserved mcmd=3 -> single response serror=1, sresp=0. Assert i_rst_n=0 mid-read -> o_sresp_valid falls immediately; post-reset read of the previously written word returns 0.
